control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/rv32i_pkg.sv | 71 +++++++
 rtl/alu_decoder.sv | 45 ++++
 rtl/control_sequencer.sv | 174 +++++++++++++++++
 tb/tb_control_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// ============================================================================
// rv32i_pkg : shared encodings for the RV32I control sequencer and datapath
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package rv32i_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OC_R      = 3'd0,
    OC_I      = 3'd1,
    OC_LOAD   = 3'd2,
    OC_STORE  = 3'd3,
    OC_BRANCH = 3'd4,
    OC_JAL    = 3'd5,
    OC_LUI    = 3'd6,
    OC_ILL    = 3'd7
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] JUMP_RESET = 2'b00;
  localparam logic [1:0] JUMP_SEQ   = 2'b01;
  localparam logic [1:0] JUMP_IMM   = 2'b10;
  localparam logic [1:0] JUMP_TRAP  = 2'b11;

  localparam logic [1:0] DATO_ALU = 2'b00;
  localparam logic [1:0] DATO_MEM = 2'b01;
  localparam logic [1:0] DATO_IMM = 2'b10;
  localparam logic [1:0] DATO_PC4 = 2'b11;

  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      OP_R:      return OC_R;
      OP_I:      return OC_I;
      OP_LOAD:   return OC_LOAD;
      OP_STORE:  return OC_STORE;
      OP_BRANCH: return OC_BRANCH;
      OP_JAL:    return OC_JAL;
      OP_LUI:    return OC_LUI;
      default:   return OC_ILL;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// alu_decoder : maps instruction class, f3 and f7 to an ALU operation
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import rv32i_pkg::*;
(
  input  op_class_t  op_class,
  input  logic [2:0] f3,
  input  logic       f7,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (op_class)
      OC_R, OC_I: begin
        case (f3)
          3'b000:  alu_op = (op_class == OC_R && f7) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b100:  alu_op = ALU_XOR;
          3'b010:  alu_op = ALU_SLT;
          3'b001:  alu_op = ALU_SLL;
          3'b101:  alu_op = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
      // Only BEQ/BNE are implemented; the compare is always a subtraction.
      OC_BRANCH: begin
        alu_op  = ALU_SUB;
        illegal = (f3[2:1] != 2'b00);
      end
      OC_ILL:  illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : multi-cycle RV32I control FSM with retired-instr counter
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module control_sequencer
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op_code,
  input  logic [2:0]  f3,
  input  logic        f7,
  input  logic        flag,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_we,
  output logic        branch,
  output logic [1:0]  jump,
  output logic [1:0]  dato_s,
  output logic        reg_w,
  output logic        alu_s,
  output logic [2:0]  alu_op,
  output logic        trap,
  output logic [31:0] instret
);

  state_t     state, state_next;
  op_class_t  cls_q, cls_live, dec_cls;
  logic [2:0] f3_q, dec_f3, dec_alu_op;
  logic       f7_q, dec_f7, dec_illegal;
  logic       boot;
  logic       retire;

  assign cls_live = classify(op_code);

  // DECODE decides on the live instruction; later states use the captured copy.
  assign dec_cls = (state == DECODE) ? cls_live : cls_q;
  assign dec_f3  = (state == DECODE) ? f3       : f3_q;
  assign dec_f7  = (state == DECODE) ? f7       : f7_q;

  alu_decoder u_alu_decoder (
    .op_class (dec_cls),
    .f3       (dec_f3),
    .f7       (dec_f7),
    .alu_op   (dec_alu_op),
    .illegal  (dec_illegal)
  );

  // The reset-address load is not a retired instruction.
  assign retire = pc_we & ~trap & ~boot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      boot    <= 1'b1;
      cls_q   <= OC_ILL;
      f3_q    <= 3'b000;
      f7_q    <= 1'b0;
      instret <= 32'd0;
    end else begin
      state <= state_next;
      boot  <= 1'b0;
      if (state == DECODE) begin
        cls_q <= cls_live;
        f3_q  <= f3;
        f7_q  <= f7;
      end
      if (retire) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    branch     = 1'b0;
    jump       = JUMP_SEQ;
    dato_s     = DATO_ALU;
    reg_w      = 1'b0;
    alu_s      = 1'b0;
    alu_op     = ALU_ADD;
    trap       = 1'b0;
    if (!rst_n) begin
      jump = JUMP_RESET;
    end else begin
      if (state inside {DECODE, EXEC, MEM, WB}) begin
        alu_op = dec_alu_op;
        alu_s  = (dec_cls inside {OC_I, OC_LOAD, OC_STORE});
      end
      case (state)
        FETCH: begin
          if (boot) begin
            pc_we = 1'b1;
            jump  = JUMP_RESET;
          end else begin
            imem_req = 1'b1;
            if (imem_ack) begin
              ir_we      = 1'b1;
              state_next = DECODE;
            end
          end
        end
        DECODE: begin
          case (cls_live)
            OC_R, OC_I:                     state_next = dec_illegal ? TRAP : EXEC;
            OC_LOAD, OC_STORE, OC_BRANCH:   state_next = EXEC;
            OC_JAL, OC_LUI:                 state_next = WB;
            default:                        state_next = TRAP;
          endcase
        end
        EXEC: begin
          case (cls_q)
            OC_LOAD, OC_STORE: state_next = MEM;
            OC_BRANCH: begin
              if (dec_illegal) begin
                state_next = TRAP;
              end else begin
                pc_we      = 1'b1;
                branch     = ((f3_q == 3'b000) && flag) || ((f3_q == 3'b001) && !flag);
                state_next = FETCH;
              end
            end
            default: state_next = WB;
          endcase
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == OC_STORE);
          if (dmem_ack) begin
            if (cls_q == OC_STORE) begin
              pc_we      = 1'b1;
              state_next = FETCH;
            end else begin
              state_next = WB;
            end
          end
        end
        WB: begin
          reg_w      = 1'b1;
          pc_we      = 1'b1;
          state_next = FETCH;
          case (cls_q)
            OC_LOAD: dato_s = DATO_MEM;
            OC_LUI:  dato_s = DATO_IMM;
            OC_JAL: begin
              dato_s = DATO_PC4;
              jump   = JUMP_IMM;
            end
            default: dato_s = DATO_ALU;
          endcase
        end
        TRAP: begin
          trap       = 1'b1;
          pc_we      = 1'b1;
          jump       = JUMP_TRAP;
          state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer : directed self-checking bench for control_sequencer
// Rev 1.0              : initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  logic        clk, rst_n;
  logic [6:0]  op_code;
  logic [2:0]  f3;
  logic        f7, flag, imem_ack, dmem_ack;
  logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, branch, reg_w, alu_s, trap;
  logic [1:0]  jump, dato_s;
  logic [2:0]  alu_op;
  logic [31:0] instret;
  logic [15:0] ctl;

  int passed = 0;
  int total  = 0;

  // {imem_req, ir_we, dmem_req, dmem_we, pc_we, branch, jump, dato_s, reg_w, alu_s, alu_op, trap}
  assign ctl = {imem_req, ir_we, dmem_req, dmem_we, pc_we, branch, jump, dato_s,
                reg_w, alu_s, alu_op, trap};

  localparam logic [15:0] V_RST  = 16'b0_0_0_0_0_0_00_00_0_0_000_0;
  localparam logic [15:0] V_BOOT = 16'b0_0_0_0_1_0_00_00_0_0_000_0;
  localparam logic [15:0] V_IDLE = 16'b1_0_0_0_0_0_01_00_0_0_000_0;
  localparam logic [15:0] V_FACK = 16'b1_1_0_0_0_0_01_00_0_0_000_0;
  localparam logic [15:0] V_TRAP = 16'b0_0_0_0_1_0_11_00_0_0_000_1;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .f3(f3), .f7(f7), .flag(flag),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_we(pc_we), .branch(branch),
    .jump(jump), .dato_s(dato_s), .reg_w(reg_w), .alu_s(alu_s), .alu_op(alu_op),
    .trap(trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; op_code = 7'd0; f3 = 3'd0; f7 = 1'b0; flag = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk); #1;
    total++; if (ctl !== V_RST) $display("FAIL reset_ctl got=%b exp=%b", ctl, V_RST); else passed++;
    total++; if (instret !== 32'd0) $display("FAIL reset_instret got=%h exp=0", instret); else passed++;
    @(negedge clk);
    rst_n = 1'b1; #1;
    total++; if (ctl !== V_BOOT) $display("FAIL boot_ctl got=%b exp=%b", ctl, V_BOOT); else passed++;
    @(negedge clk); #1;
    total++; if (ctl !== V_IDLE) $display("FAIL fetch_idle got=%b exp=%b", ctl, V_IDLE); else passed++;
    total++; if (instret !== 32'd0) $display("FAIL boot_instret got=%h exp=0", instret); else passed++;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [15:0] exp [4];
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_000_0, 16'b0_0_0_0_0_0_01_00_0_0_000_0,
            16'b0_0_0_0_1_0_01_00_1_0_000_0};
    op_code = 7'b0110011; f3 = 3'b000; f7 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 0); #1;
      total++; if (ctl !== exp[i]) $display("FAIL add cyc%0d got=%b exp=%b", i, ctl, exp[i]); else passed++;
      @(negedge clk);
    end
    #1;
    total++; if (instret !== 32'd1) $display("FAIL add_instret got=%h exp=1", instret); else passed++;
  endtask

  task automatic test_alu_decode();
    logic [6:0]  ops [3];
    logic [2:0]  f3s [3];
    logic        f7s [3];
    logic [15:0] exp [12];
    ops = '{7'b0110011, 7'b0010011, 7'b0110011};
    f3s = '{3'b000, 3'b100, 3'b011};
    f7s = '{1'b1, 1'b1, 1'b0};
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_001_0, 16'b0_0_0_0_0_0_01_00_0_0_001_0,
            16'b0_0_0_0_1_0_01_00_1_0_001_0,
            V_FACK, 16'b0_0_0_0_0_0_01_00_0_1_100_0, 16'b0_0_0_0_0_0_01_00_0_1_100_0,
            16'b0_0_0_0_1_0_01_00_1_1_100_0,
            V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_000_0, V_TRAP, V_IDLE};
    for (int k = 0; k < 3; k++) begin
      op_code = ops[k]; f3 = f3s[k]; f7 = f7s[k];
      for (int i = 0; i < 4; i++) begin
        imem_ack = (i == 0); #1;
        total++;
        if (ctl !== exp[4*k+i]) $display("FAIL alu_dec k%0d cyc%0d got=%b exp=%b", k, i, ctl, exp[4*k+i]);
        else passed++;
        @(negedge clk);
      end
    end
    #1;
    total++; if (instret !== 32'd3) $display("FAIL alu_dec_instret got=%h exp=3", instret); else passed++;
  endtask

  task automatic test_load_wait();
    logic [15:0] exp [8];
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_1_000_0, 16'b0_0_0_0_0_0_01_00_0_1_000_0,
            16'b0_0_1_0_0_0_01_00_0_1_000_0, 16'b0_0_1_0_0_0_01_00_0_1_000_0,
            16'b0_0_1_0_0_0_01_00_0_1_000_0, 16'b0_0_1_0_0_0_01_00_0_1_000_0,
            16'b0_0_0_0_1_0_01_01_1_1_000_0};
    op_code = 7'b0000011; f3 = 3'b010; f7 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      imem_ack = (i == 0);
      dmem_ack = (i == 6);
      // After DECODE the live fields become garbage; the captured copy must be used.
      if (i == 2) begin op_code = 7'b1111111; f3 = 3'b011; f7 = 1'b1; end
      #1;
      total++; if (ctl !== exp[i]) $display("FAIL lw cyc%0d got=%b exp=%b", i, ctl, exp[i]); else passed++;
      @(negedge clk);
    end
    dmem_ack = 1'b0; #1;
    total++; if (instret !== 32'd4) $display("FAIL lw_instret got=%h exp=4", instret); else passed++;
  endtask

  task automatic test_branch();
    logic [2:0]  f3s [3];
    logic [15:0] exp [12];
    f3s = '{3'b000, 3'b001, 3'b010};
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_001_0, 16'b0_0_0_0_1_1_01_00_0_0_001_0, V_IDLE,
            V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_001_0, 16'b0_0_0_0_1_0_01_00_0_0_001_0, V_IDLE,
            V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_001_0, 16'b0_0_0_0_0_0_01_00_0_0_001_0, V_TRAP};
    op_code = 7'b1100011; f7 = 1'b0; flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f3 = f3s[k];
      for (int i = 0; i < 4; i++) begin
        imem_ack = (i == 0); #1;
        total++;
        if (ctl !== exp[4*k+i]) $display("FAIL branch k%0d cyc%0d got=%b exp=%b", k, i, ctl, exp[4*k+i]);
        else passed++;
        @(negedge clk);
      end
    end
    flag = 1'b0; #1;
    total++; if (instret !== 32'd6) $display("FAIL branch_instret got=%h exp=6", instret); else passed++;
  endtask

  task automatic test_illegal();
    logic [15:0] exp [4];
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_000_0, V_TRAP, V_IDLE};
    op_code = 7'b1111111; f3 = 3'b000; f7 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 0); #1;
      total++; if (ctl !== exp[i]) $display("FAIL illegal cyc%0d got=%b exp=%b", i, ctl, exp[i]); else passed++;
      @(negedge clk);
    end
    #1;
    total++; if (instret !== 32'd6) $display("FAIL illegal_instret got=%h exp=6", instret); else passed++;
  endtask

  task automatic test_store();
    logic [15:0] exp [5];
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_1_000_0, 16'b0_0_0_0_0_0_01_00_0_1_000_0,
            16'b0_0_1_1_1_0_01_00_0_1_000_0, V_IDLE};
    op_code = 7'b0100011; f3 = 3'b010; f7 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 0); dmem_ack = (i == 3); #1;
      total++; if (ctl !== exp[i]) $display("FAIL sw cyc%0d got=%b exp=%b", i, ctl, exp[i]); else passed++;
      @(negedge clk);
    end
    dmem_ack = 1'b0; #1;
    total++; if (instret !== 32'd7) $display("FAIL sw_instret got=%h exp=7", instret); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [4];
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_1_000_0, 16'b0_0_0_0_0_0_01_00_0_1_000_0,
            16'b0_0_1_1_0_0_01_00_0_1_000_0};
    op_code = 7'b0100011; f3 = 3'b010; f7 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 0); #1;
      total++; if (ctl !== exp[i]) $display("FAIL rst_mid cyc%0d got=%b exp=%b", i, ctl, exp[i]); else passed++;
      if (i < 3) @(negedge clk);
    end
    #2 rst_n = 1'b0; #1;
    total++; if (ctl !== V_RST) $display("FAIL rst_async got=%b exp=%b", ctl, V_RST); else passed++;
    @(negedge clk);
    dmem_ack = 1'b1; #1;
    total++; if (ctl !== V_RST) $display("FAIL rst_late_ack got=%b exp=%b", ctl, V_RST); else passed++;
    @(negedge clk);
    rst_n = 1'b1; #1;
    total++; if (ctl !== V_BOOT) $display("FAIL rst_reboot got=%b exp=%b", ctl, V_BOOT); else passed++;
    total++; if (instret !== 32'd0) $display("FAIL rst_instret got=%h exp=0", instret); else passed++;
    @(negedge clk);
    dmem_ack = 1'b0; #1;
    total++; if (ctl !== V_IDLE) $display("FAIL rst_refetch got=%b exp=%b", ctl, V_IDLE); else passed++;
    @(negedge clk);
  endtask

  task automatic test_instret_wrap();
    logic [6:0]  ops [2];
    logic [15:0] exp [6];
    logic [31:0] ret [2];
    ops = '{7'b0110111, 7'b1101111};
    ret = '{32'hFFFF_FFFF, 32'h0000_0000};
    exp = '{V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_000_0, 16'b0_0_0_0_1_0_01_10_1_0_000_0,
            V_FACK, 16'b0_0_0_0_0_0_01_00_0_0_000_0, 16'b0_0_0_0_1_0_10_11_1_0_000_0};
    force dut.instret = 32'hFFFF_FFFE;
    #1 release dut.instret;
    total++; if (instret !== 32'hFFFF_FFFE) $display("FAIL wrap_preset got=%h exp=fffffffe", instret); else passed++;
    f3 = 3'b000; f7 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op_code = ops[k];
      for (int i = 0; i < 3; i++) begin
        imem_ack = (i == 0); #1;
        total++;
        if (ctl !== exp[3*k+i]) $display("FAIL wrap k%0d cyc%0d got=%b exp=%b", k, i, ctl, exp[3*k+i]);
        else passed++;
        @(negedge clk);
      end
      #1;
      total++; if (instret !== ret[k]) $display("FAIL wrap_count k%0d got=%h exp=%h", k, instret, ret[k]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_decode();
    test_load_wait();
    test_branch();
    test_illegal();
    test_store();
    test_reset_mid();
    test_instret_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
